dac_seg_sequencer: RTL and testbench

Digital controller that sequences and feeds the segmented current-steering DAC driver cell (7 binary LSBs + 17 unary thermometer units).
- Owns driver power-up/power-down (`pdb`), supply-fault shutdown, code acceptance handshake, saturation, binary/thermometer split, and data-weighted-averaging (DWA) rotation of thermometer units.
- Sits between the DSP code source and the driver cell's `datain/datainb/datatherm/datathermb/pdb` inputs.

---
 rtl/dac_seg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_dac_seg_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dac_seg_sequencer.sv
// Sequencer for the segmented current-steering DAC driver: power-up/down, supply-fault
// shutdown, code handshake, saturation, binary/thermometer split and DWA unit rotation.
module dac_seg_sequencer #(
   parameter int WAKE_CYCLES = 16,
   parameter int NBIN        = 7,
   parameter int NTHERM      = 17,
   parameter int CODE_W      = 12
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              enable,
   input  logic              supply_ok,
   input  logic              dwa_en,
   input  logic [CODE_W-1:0] code,
   input  logic              code_valid,
   output logic              code_ready,
   output logic              pdb,
   output logic [NBIN-1:0]   datain,
   output logic [NBIN-1:0]   datainb,
   output logic [NTHERM-1:0] datatherm,
   output logic [NTHERM-1:0] datathermb,
   output logic [1:0]        state,
   output logic              sat,
   output logic              fault
);

   localparam int MAX_CODE = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;
   localparam int K_W      = $clog2(NTHERM + 1);
   localparam int P_W      = $clog2(NTHERM);
   localparam int CNT_W    = $clog2(WAKE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'b00,
      ST_WAKE = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
      if (c > CODE_W'(MAX_CODE)) return CODE_W'(MAX_CODE);
      return c;
   endfunction

   // k consecutive units starting at unit p, wrapping modulo NTHERM
   function automatic logic [NTHERM-1:0] therm_fill(input logic [K_W-1:0] k,
                                                    input logic [P_W-1:0] p);
      logic [NTHERM-1:0]   m;
      logic [2*NTHERM-1:0] r;
      for (int i = 0; i < NTHERM; i++) m[i] = (i < int'(k));
      r = {m, m} << p;
      return r[2*NTHERM-1:NTHERM];
   endfunction

   function automatic logic [P_W-1:0] ptr_adv(input logic [P_W-1:0] p,
                                              input logic [K_W-1:0] k);
      logic [K_W:0] s;
      s = (K_W+1)'(p) + (K_W+1)'(k);
      if (s >= (K_W+1)'(NTHERM)) s = s - (K_W+1)'(NTHERM);
      return P_W'(s);
   endfunction

   state_t             state_r, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               fault_nxt;
   logic               ok_m, ok_s;
   logic [P_W-1:0]     ptr;

   logic [CODE_W-1:0]  code_p0;
   logic               dwa_p0;
   logic               vld_p0;
   logic [CODE_W-1:0]  c_p0;
   logic [K_W-1:0]     k_p0;
   logic [NTHERM-1:0]  therm_p0;

   assign state      = state_r;
   assign code_ready = (state_r == ST_RUN);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ok_m    <= 1'b0;
         ok_s    <= 1'b0;
         state_r <= ST_OFF;
         cnt     <= '0;
         fault   <= 1'b0;
      end else begin
         ok_m    <= supply_ok;
         ok_s    <= ok_m;
         state_r <= state_nxt;
         cnt     <= cnt_nxt;
         fault   <= fault_nxt;
      end
   end

   // Supply loss outranks a dropped enable so the fault is always recorded
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt;
      fault_nxt = fault;
      case (state_r)
         ST_OFF: begin
            cnt_nxt = '0;
            if (!enable) fault_nxt = 1'b0;
            if (enable && ok_s && !fault) state_nxt = ST_WAKE;
         end
         ST_WAKE, ST_RUN: begin
            if (!ok_s) begin
               state_nxt = ST_OFF;
               fault_nxt = 1'b1;
               cnt_nxt   = '0;
            end else if (!enable) begin
               state_nxt = ST_OFF;
               cnt_nxt   = '0;
            end else if (state_r == ST_WAKE) begin
               if (cnt == CNT_W'(WAKE_CYCLES - 1)) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Stage p0: accepted code
   always_ff @(posedge clk) begin
      if (code_valid && code_ready) begin
         code_p0 <= code;
         dwa_p0  <= dwa_en;
      end
   end

   always_comb begin
      c_p0     = sat_code(code_p0);
      k_p0     = K_W'(c_p0 >> NBIN);
      therm_p0 = therm_fill(k_p0, dwa_p0 ? ptr : '0);
   end

   // Stage p1: driver outputs, true and complement from the same flops
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         vld_p0     <= 1'b0;
         ptr        <= '0;
         pdb        <= 1'b0;
         datain     <= '0;
         datainb    <= '1;
         datatherm  <= '0;
         datathermb <= '1;
         sat        <= 1'b0;
      end else begin
         pdb    <= (state_nxt != ST_OFF);
         vld_p0 <= code_valid && code_ready && (state_nxt != ST_OFF);
         if (state_nxt == ST_OFF) begin
            ptr        <= '0;
            datain     <= '0;
            datainb    <= '1;
            datatherm  <= '0;
            datathermb <= '1;
            sat        <= 1'b0;
         end else if (vld_p0) begin
            datain     <= c_p0[NBIN-1:0];
            datainb    <= ~c_p0[NBIN-1:0];
            datatherm  <= therm_p0;
            datathermb <= ~therm_p0;
            sat        <= (code_p0 > CODE_W'(MAX_CODE));
            if (dwa_p0) ptr <= ptr_adv(ptr, k_p0);
         end
      end
   end

endmodule

// File: tb/tb_dac_seg_sequencer.sv
// Directed-vector bench for dac_seg_sequencer: reset, wake-up timing, DWA rotation,
// saturation, fixed fill, async reset mid-transfer and supply-fault handling.
module tb_dac_seg_sequencer;

   logic        clk = 1'b0;
   logic        rstb;
   logic        enable;
   logic        supply_ok;
   logic        dwa_en;
   logic [11:0] code;
   logic        code_valid;
   logic        code_ready;
   logic        pdb;
   logic [6:0]  datain;
   logic [6:0]  datainb;
   logic [16:0] datatherm;
   logic [16:0] datathermb;
   logic [1:0]  state;
   logic        sat;
   logic        fault;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dac_seg_sequencer #(
      .WAKE_CYCLES(16), .NBIN(7), .NTHERM(17), .CODE_W(12)
   ) dut (
      .clk(clk), .rstb(rstb), .enable(enable), .supply_ok(supply_ok),
      .dwa_en(dwa_en), .code(code), .code_valid(code_valid),
      .code_ready(code_ready), .pdb(pdb), .datain(datain), .datainb(datainb),
      .datatherm(datatherm), .datathermb(datathermb), .state(state),
      .sat(sat), .fault(fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accepted on the first rising edge, visible after the second
   task automatic send(input logic [11:0] c);
      code       = c;
      code_valid = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_data(input string tag, input logic [6:0] bin,
                           input logic [16:0] th, input logic s);
      chk({tag, ".datain"}, 32'(datain), 32'(bin));
      chk({tag, ".therm"}, 32'(datatherm), 32'(th));
      chk({tag, ".sat"}, 32'(sat), 32'(s));
   endtask

   initial begin
      rstb = 1'b0; enable = 1'b1; supply_ok = 1'b1; dwa_en = 1'b1;
      code = '0; code_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.state", 32'(state), 32'h0);
      chk("rst.pdb", 32'(pdb), 32'h0);
      chk("rst.thermb", 32'(datathermb), 32'h1FFFF);
      chk("rst.inb", 32'(datainb), 32'h7F);
      chk("rst.ready", 32'(code_ready), 32'h0);
      chk("rst.therm", 32'(datatherm), 32'h0);
      chk("rst.fault", 32'(fault), 32'h0);

      enable = 1'b0;
      rstb   = 1'b1;
      repeat (3) @(negedge clk);
      chk("off.state", 32'(state), 32'h0);

      // Wake-up: pdb one edge after enable, RUN 16 edges later
      enable = 1'b1;
      @(negedge clk);
      chk("wake.state", 32'(state), 32'h1);
      chk("wake.pdb", 32'(pdb), 32'h1);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("wake.ready%0d", i), 32'(code_ready), 32'h0);
         chk($sformatf("wake.therm%0d", i), 32'(datatherm), 32'h0);
      end
      @(negedge clk);
      chk("run.ready", 32'(code_ready), 32'h1);
      chk("run.state", 32'(state), 32'h2);
      chk("run.pdb", 32'(pdb), 32'h1);

      send(12'd384);
      chk_data("dwa384a", 7'h00, 17'h00007, 1'b0);
      send(12'd384);
      chk_data("dwa384b", 7'h00, 17'h00038, 1'b0);
      chk("dwa384b.thermb", 32'(datathermb), 32'h1FFC7);
      repeat (3) @(negedge clk);
      chk("hold.therm", 32'(datatherm), 32'h00038);

      // Async reset right after an accepting edge: immediate, pending code dropped
      code = 12'd384; code_valid = 1'b1;
      @(posedge clk);
      #2 rstb = 1'b0;
      #1;
      chk("arst.state", 32'(state), 32'h0);
      chk("arst.pdb", 32'(pdb), 32'h0);
      chk("arst.therm", 32'(datatherm), 32'h0);
      chk("arst.thermb", 32'(datathermb), 32'h1FFFF);
      code_valid = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      repeat (19) @(negedge clk);
      chk("rerun.state", 32'(state), 32'h2);
      chk("rerun.therm", 32'(datatherm), 32'h0);

      send(12'd640);
      chk_data("w640a", 7'h00, 17'h0001F, 1'b0);
      send(12'd640);
      chk_data("w640b", 7'h00, 17'h003E0, 1'b0);
      send(12'd640);
      chk_data("w640c", 7'h00, 17'h07C00, 1'b0);
      send(12'd384);
      chk_data("wrap384", 7'h00, 17'h18001, 1'b0);

      send(12'hFFF);
      chk_data("satfff", 7'h7F, 17'h1FFFF, 1'b1);
      chk("satfff.inb", 32'(datainb), 32'h00);
      send(12'd2303);
      chk_data("fs2303", 7'h7F, 17'h1FFFF, 1'b0);
      send(12'd384);
      chk_data("p1check", 7'h00, 17'h0000E, 1'b0);

      dwa_en = 1'b0;
      send(12'd645);
      chk_data("fix645", 7'h05, 17'h0001F, 1'b0);
      chk("fix645.inb", 32'(datainb), 32'h7A);
      dwa_en = 1'b1;
      send(12'd384);
      chk_data("p4check", 7'h00, 17'h00070, 1'b0);
      chk("p4check.thermb", 32'(datathermb), 32'h1FF8F);

      // Supply loss: OFF and fault on the third edge
      supply_ok = 1'b0;
      @(negedge clk);
      chk("sl.e1", 32'(state), 32'h2);
      @(negedge clk);
      chk("sl.e2", 32'(pdb), 32'h1);
      @(negedge clk);
      chk("sl.state", 32'(state), 32'h0);
      chk("sl.pdb", 32'(pdb), 32'h0);
      chk("sl.fault", 32'(fault), 32'h1);
      chk("sl.therm", 32'(datatherm), 32'h0);
      chk("sl.inb", 32'(datainb), 32'h7F);
      supply_ok = 1'b1;
      repeat (5) @(negedge clk);
      chk("sl.stayoff", 32'(state), 32'h0);
      chk("sl.sticky", 32'(fault), 32'h1);
      enable = 1'b0;
      @(negedge clk);
      chk("sl.clear", 32'(fault), 32'h0);
      enable = 1'b1;
      @(negedge clk);
      chk("sl.rewake", 32'(state), 32'h1);
      chk("sl.repdb", 32'(pdb), 32'h1);

      // Dropping enable during WAKE aborts without a fault
      enable = 1'b0;
      @(negedge clk);
      chk("en.abort", 32'(state), 32'h0);
      chk("en.nofault", 32'(fault), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
